// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: 3-stage pipelined RGB888 -> HSV converter (hue in degrees 0..359).
// Define RGB2HSV_VALID_EN to add the in_valid/out_valid sideband (3-edge delay).
module rgb_to_hsv #(
    parameter int H_W = 10
) (
`ifdef RGB2HSV_VALID_EN
    input  logic           in_valid,
    output logic           out_valid,
`endif
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rgb_r,
    input  logic [7:0]     rgb_g,
    input  logic [7:0]     rgb_b,
    output logic [H_W-1:0] hsv_h,
    output logic [7:0]     hsv_s,
    output logic [7:0]     hsv_v
);
    logic              r_max, g_max;
    logic [7:0]        min_c;
    logic [7:0]        max1_d, max1_q, dlt1_d, dlt1_q;
    logic [1:0]        sel1_d, sel1_q, sel2_q;
    logic signed [8:0] dif1_d, dif1_q;
    logic [7:0]        adif, den_h, den_s;
    logic [13:0]       num_h;
    logic [15:0]       num_s;
    logic [5:0]        qh2_d, qh2_q;
    logic [7:0]        qs2_d, qs2_q, v2_q;
    logic              neg2_q, zero2_q;
    logic [10:0]       base, hsum, hwrap;
    logic [H_W-1:0]    h3_d, h3_q;
    logic [7:0]        s3_q, v3_q;

    always_comb begin
        r_max  = rgb_r >= rgb_g && rgb_r >= rgb_b;
        g_max  = !r_max && rgb_g >= rgb_b;
        sel1_d = r_max ? 2'd0 : g_max ? 2'd1 : 2'd2;
        max1_d = r_max ? rgb_r : g_max ? rgb_g : rgb_b;
        min_c  = (rgb_r <= rgb_g && rgb_r <= rgb_b) ? rgb_r : (rgb_g <= rgb_b) ? rgb_g : rgb_b;
        dlt1_d = max1_d - min_c;
        dif1_d = r_max ? $signed({1'b0, rgb_g}) - $signed({1'b0, rgb_b}) :
                 g_max ? $signed({1'b0, rgb_b}) - $signed({1'b0, rgb_r}) :
                         $signed({1'b0, rgb_r}) - $signed({1'b0, rgb_g});
    end

    // zero denominators only occur with zero numerators; forcing 1 keeps the quotient 0
    always_comb begin
        adif  = dif1_q[8] ? 8'(-dif1_q) : dif1_q[7:0];
        den_h = dlt1_q == 8'd0 ? 8'd1 : dlt1_q;
        den_s = max1_q == 8'd0 ? 8'd1 : max1_q;
        num_h = 14'd60 * {6'd0, adif};
        num_s = 16'd255 * {8'd0, dlt1_q};
        qh2_d = 6'(num_h / {6'd0, den_h});
        qs2_d = 8'(num_s / {8'd0, den_s});
    end

    // base already carries the +360 so the signed offset never goes negative
    always_comb begin
        base  = sel2_q == 2'd0 ? 11'd360 : sel2_q == 2'd1 ? 11'd480 : 11'd600;
        hsum  = neg2_q ? base - {5'd0, qh2_q} : base + {5'd0, qh2_q};
        hwrap = hsum >= 11'd360 ? hsum - 11'd360 : hsum;
        h3_d  = zero2_q ? '0 : H_W'(hwrap);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max1_q  <= '0;
            dlt1_q  <= '0;
            sel1_q  <= '0;
            dif1_q  <= '0;
            qh2_q   <= '0;
            qs2_q   <= '0;
            v2_q    <= '0;
            sel2_q  <= '0;
            neg2_q  <= 1'b0;
            zero2_q <= 1'b0;
            h3_q    <= '0;
            s3_q    <= '0;
            v3_q    <= '0;
        end else begin
            max1_q  <= max1_d;
            dlt1_q  <= dlt1_d;
            sel1_q  <= sel1_d;
            dif1_q  <= dif1_d;
            qh2_q   <= qh2_d;
            qs2_q   <= qs2_d;
            v2_q    <= max1_q;
            sel2_q  <= sel1_q;
            neg2_q  <= dif1_q[8];
            zero2_q <= dlt1_q == 8'd0;
            h3_q    <= h3_d;
            s3_q    <= qs2_q;
            v3_q    <= v2_q;
        end
    end

    assign hsv_h = h3_q;
    assign hsv_s = s3_q;
    assign hsv_v = v3_q;

`ifdef RGB2HSV_VALID_EN
    logic [2:0] vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= {vld_q[1:0], in_valid};
    end

    assign out_valid = vld_q[2];
`endif
endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb_rgb_to_hsv: scoreboard bench for rgb_to_hsv; expectations queued at drive time.
module tb_rgb_to_hsv;
    typedef struct {
        int h;
        int s;
        int v;
        bit vld;
    } exp_t;

    typedef struct {
        logic [7:0] r, g, b;
        int         h, s, v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rgb_r = '0, rgb_g = '0, rgb_b = '0;
    logic [9:0] hsv_h;
    logic [7:0] hsv_s, hsv_v;
    logic       in_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       zero_e = '{0, 0, 0, 1'b0};
    vec_t       dir[11];

    always #5 clk = ~clk;

    rgb_to_hsv #(.H_W(10)) dut (
`ifdef RGB2HSV_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .clk  (clk),
        .rst  (rst),
        .rgb_r(rgb_r),
        .rgb_g(rgb_g),
        .rgb_b(rgb_b),
        .hsv_h(hsv_h),
        .hsv_s(hsv_s),
        .hsv_v(hsv_v)
    );
`ifdef RGB2HSV_VALID_EN
    logic out_valid;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int r, input int g, input int b, input bit vld);
        exp_t e;
        int mx, mn, d, diff, base, q;
        mx = r; mn = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        d = mx - mn;
        e.v = mx;
        e.s = (mx == 0 || d == 0) ? 0 : 255 * d / mx;
        e.vld = vld;
        if (d == 0) begin
            e.h = 0;
        end else begin
            if (r == mx) begin base = 0; diff = g - b; end
            else if (g == mx) begin base = 120; diff = b - r; end
            else begin base = 240; diff = r - g; end
            q = 60 * (diff < 0 ? -diff : diff) / d;
            e.h = (360 + base + (diff < 0 ? -q : q)) % 360;
        end
        return e;
    endfunction

    task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input exp_t e);
        exp_t o;
        @(negedge clk);
        rgb_r = r; rgb_g = g; rgb_b = b; in_valid = e.vld;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("h", int'(hsv_h), o.h);
        chk("s", int'(hsv_s), o.s);
        chk("v", int'(hsv_v), o.v);
`ifdef RGB2HSV_VALID_EN
        chk("out_valid", int'(out_valid), int'(o.vld));
`endif
    endtask

    task automatic release_rst();
        @(negedge clk);
        rgb_r = '0; rgb_g = '0; rgb_b = '0; in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        sb.push_back(zero_e);
        sb.push_back(zero_e);
    endtask

    initial begin
        dir[0]  = '{8'd255, 8'd0,   8'd0,   0,   255, 255};
        dir[1]  = '{8'd0,   8'd255, 8'd0,   120, 255, 255};
        dir[2]  = '{8'd0,   8'd0,   8'd255, 240, 255, 255};
        dir[3]  = '{8'd128, 8'd128, 8'd128, 0,   0,   128};
        dir[4]  = '{8'd0,   8'd0,   8'd0,   0,   0,   0};
        dir[5]  = '{8'd255, 8'd255, 8'd255, 0,   0,   255};
        dir[6]  = '{8'd200, 8'd100, 8'd50,  20,  191, 200};
        dir[7]  = '{8'd255, 8'd0,   8'd128, 330, 255, 255};
        dir[8]  = '{8'd255, 8'd255, 8'd0,   60,  255, 255};
        dir[9]  = '{8'd0,   8'd255, 8'd255, 180, 255, 255};
        dir[10] = '{8'd255, 8'd0,   8'd255, 300, 255, 255};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_h", int'(hsv_h), 0);
        chk("rst_s", int'(hsv_s), 0);
        chk("rst_v", int'(hsv_v), 0);
        release_rst();
        foreach (dir[i])
            step(dir[i].r, dir[i].g, dir[i].b, '{dir[i].h, dir[i].s, dir[i].v, 1'b1});
        for (int i = 0; i < 100; i++) begin
            logic [7:0] r, g, b;
            bit         vl;
            r = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            vl = 1'($urandom_range(0, 1));
            step(r, g, b, model(r, g, b, vl));
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_h", int'(hsv_h), 0);
        chk("async_rst_s", int'(hsv_s), 0);
        chk("async_rst_v", int'(hsv_v), 0);
        repeat (2) @(posedge clk);
        release_rst();
        step(8'd200, 8'd100, 8'd50, '{20, 191, 200, 1'b1});
        for (int i = 0; i < 20; i++) begin
            logic [7:0] r, g, b;
            r = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            step(r, g, b, model(r, g, b, 1'b1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
